// File: rtl/difftest_commit_ctrl.sv
// Commit sequencer between NPC writeback and the DPI-C difftest checker: FWFT FIFO,
// valid/ready back-pressure, halt draining, instret. Optional watchdog: DIFFTEST_WDOG_EN.
module difftest_commit_ctrl #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dt_en,
  input  logic        cmt_valid,
  output logic        cmt_ready,
  input  logic [31:0] cmt_pc,
  input  logic        cmt_skip,
  input  logic        cmt_halt,
  input  logic        cmt_rd_wen,
  input  logic [4:0]  cmt_rd,
  input  logic [31:0] cmt_rd_data,
  output logic        dt_valid,
  input  logic        dt_ready,
  output logic [31:0] dt_pc,
  output logic        dt_skip,
  output logic        dt_rd_wen,
  output logic [4:0]  dt_rd,
  output logic [31:0] dt_rd_data,
  output logic [31:0] instret,
  output logic        halted,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WDOG_LIMIT < 1) begin : g_bad_cfg
    $error("difftest_commit_ctrl: DEPTH must be a power of two >= 2, WDOG_LIMIT >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    HALTED,
    ERROR
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        skip;
    logic        halt;
    logic        rd_wen;
    logic [4:0]  rd;
    logic [31:0] rd_data;
  } entry_t;

  state_t        state, state_nxt;
  entry_t        mem [DEPTH];
  entry_t        head;
  entry_t        wr_entry;
  logic [AW-1:0] rptr, wptr;
  logic [AW:0]   count;
  logic          full, empty;
  logic          push, pop;
  logic          wdog_expire;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];

  assign cmt_ready = (state == RUN) && !full;
  assign dt_valid  = !empty && ((state == RUN) || (state == DRAIN));
  assign push      = cmt_valid && cmt_ready;
  assign pop       = dt_valid && dt_ready;

  always_comb begin
    wr_entry         = '0;
    wr_entry.pc      = cmt_pc;
    wr_entry.skip    = cmt_skip;
    wr_entry.halt    = cmt_halt;
    wr_entry.rd_wen  = cmt_rd_wen && (cmt_rd != 5'd0);
    wr_entry.rd      = cmt_rd;
    wr_entry.rd_data = cmt_rd_data;
  end

  // Storage is not reset; the outputs are masked while nothing valid is presented.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr    <= '0;
      wptr    <= '0;
      count   <= '0;
      instret <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr    <= rptr + 1'b1;
        instret <= instret + 32'd1;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

`ifdef DIFFTEST_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_LIMIT + 1);
  logic [WW-1:0] wdog;

  assign wdog_expire = (state == RUN) && !push && (wdog == WW'(WDOG_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || state != RUN || push) wdog <= '0;
    else                                wdog <= wdog + 1'b1;
  end

  assign err = (state == ERROR);
`else
  assign wdog_expire = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (dt_en) state_nxt = RUN;
      RUN: begin
        if (push && cmt_halt) state_nxt = DRAIN;
        else if (wdog_expire) state_nxt = ERROR;
      end
      // The halt entry is always the last one queued, so its pop empties the FIFO.
      DRAIN:   if (pop && head.halt) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = IDLE;
    endcase
  end

  assign halted = (state == HALTED);

  always_comb begin
    dt_pc      = '0;
    dt_skip    = 1'b0;
    dt_rd_wen  = 1'b0;
    dt_rd      = '0;
    dt_rd_data = '0;
    if (dt_valid) begin
      dt_pc      = head.pc;
      dt_skip    = head.skip;
      dt_rd_wen  = head.rd_wen;
      dt_rd      = head.rd;
      dt_rd_data = head.rd_data;
    end
  end

endmodule

// File: tb/tb_difftest_commit_ctrl.sv
// Scoreboard bench for difftest_commit_ctrl: queue-based reference model, randomized
// and directed commit traffic, independent pop monitor.
module tb_difftest_commit_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WDOG  = 8;

  logic        clk = 1'b0;
  logic        rst_n, dt_en, cmt_valid, cmt_ready;
  logic [31:0] cmt_pc;
  logic        cmt_skip, cmt_halt, cmt_rd_wen;
  logic [4:0]  cmt_rd;
  logic [31:0] cmt_rd_data;
  logic        dt_valid, dt_ready;
  logic [31:0] dt_pc;
  logic        dt_skip, dt_rd_wen;
  logic [4:0]  dt_rd;
  logic [31:0] dt_rd_data, instret;
  logic        halted, err;

  always #5 clk = ~clk;

  difftest_commit_ctrl #(.DEPTH(DEPTH), .WDOG_LIMIT(WDOG)) dut (
    .clk(clk), .rst_n(rst_n), .dt_en(dt_en),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_pc(cmt_pc),
    .cmt_skip(cmt_skip), .cmt_halt(cmt_halt), .cmt_rd_wen(cmt_rd_wen),
    .cmt_rd(cmt_rd), .cmt_rd_data(cmt_rd_data),
    .dt_valid(dt_valid), .dt_ready(dt_ready), .dt_pc(dt_pc), .dt_skip(dt_skip),
    .dt_rd_wen(dt_rd_wen), .dt_rd(dt_rd), .dt_rd_data(dt_rd_data),
    .instret(instret), .halted(halted), .err(err)
  );

  typedef struct {
    logic [31:0] pc;
    logic        skip;
    logic        halt;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Reference model: commits in flight, plus the externally visible milestones.
  ent_t        mq[$];
  ent_t        sb[$];
  bit          m_run, m_halt_in, m_halted, m_err;
  int unsigned m_idle;
  logic [31:0] m_inst;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic bit exp_ready();
    return m_run && !m_halt_in && !m_err && (mq.size() < DEPTH);
  endfunction

  function automatic bit exp_valid();
    return m_run && !m_err && !m_halted && (mq.size() > 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_run = 0; m_halt_in = 0; m_halted = 0; m_err = 0;
    m_idle = 0; m_inst = '0;
  endtask

  task automatic cyc(input bit rst, input bit en, input bit v, input logic [31:0] pc,
                     input bit skip, input bit halt, input bit wen, input logic [4:0] rd,
                     input logic [31:0] data, input bit rdy);
    bit   acc, pp, in_run;
    ent_t e;
    @(negedge clk);
    rst_n = !rst; dt_en = en; cmt_valid = v; cmt_pc = pc; cmt_skip = skip;
    cmt_halt = halt; cmt_rd_wen = wen; cmt_rd = rd; cmt_rd_data = data; dt_ready = rdy;
    #1;
    chk("cmt_ready", cmt_ready, exp_ready());
    chk("dt_valid", dt_valid, exp_valid());
    chk("instret", instret, m_inst);
    chk("halted", halted, m_halted);
    chk("err", err, m_err);
    if (!exp_valid())
      chk("dt_fields_zero", {dt_pc, dt_skip, dt_rd_wen, dt_rd, dt_rd_data}, '0);
    acc    = v && exp_ready();
    pp     = rdy && exp_valid();
    in_run = m_run && !m_halt_in && !m_err;
    @(posedge clk);
    if (rst) model_reset();
    else if (!m_run) begin
      if (en) m_run = 1;
    end else if (!m_err) begin
      if (pp) begin
        e = mq.pop_front();
        m_inst = m_inst + 32'd1;
        if (e.halt) m_halted = 1;
      end
      if (acc) begin
        e.pc = pc; e.skip = skip; e.halt = halt; e.wen = wen; e.rd = rd; e.data = data;
        mq.push_back(e);
        sb.push_back(e);
        if (halt) m_halt_in = 1;
      end
`ifdef DIFFTEST_WDOG_EN
      if (in_run) begin
        m_idle = acc ? 0 : m_idle + 1;
        if (m_idle == WDOG) m_err = 1;
      end
`else
      if (in_run) m_idle = acc ? 0 : m_idle + 1;
`endif
    end
  endtask

  task automatic idle(input bit en, input bit rdy);
    cyc(0, en, 0, '0, 0, 0, 0, '0, '0, rdy);
  endtask

  task automatic push(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data,
                      input bit wen, input bit halt, input bit rdy);
    cyc(0, 1, 1, pc, 0, halt, wen, rd, data, rdy);
  endtask

  task automatic rnd(input int unsigned n, input bit allow_halt);
    for (int unsigned i = 0; i < n; i++)
      cyc(0, 1'($urandom), ($urandom % 4) != 0, $urandom, 1'($urandom),
          allow_halt && (($urandom % 64) == 0), 1'($urandom), 5'($urandom % 32), $urandom,
          ($urandom % 3) != 0);
  endtask

  // Monitor: every handshake pops the scoreboard and compares the presented head.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && dt_valid === 1'b1 && dt_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop actual=pc %0h required=no entry", dt_pc);
        end else begin
          e = sb.pop_front();
          chk("dt_pc", dt_pc, e.pc);
          chk("dt_skip", dt_skip, e.skip);
          chk("dt_rd_wen", dt_rd_wen, e.wen && (e.rd != 5'd0));
          chk("dt_rd", dt_rd, e.rd);
          chk("dt_rd_data", dt_rd_data, e.data);
        end
      end
    end
  end

  initial begin
    rst_n = 0; dt_en = 0; cmt_valid = 0; cmt_pc = '0; cmt_skip = 0; cmt_halt = 0;
    cmt_rd_wen = 0; cmt_rd = '0; cmt_rd_data = '0; dt_ready = 0;
    model_reset();

    repeat (3) cyc(1, 0, 0, '0, 0, 0, 0, '0, '0, 0);
    idle(0, 1);
    idle(1, 1);

    // First commit and its one-cycle latency.
    push(32'h8000_0000, 5'd5, 32'h1234, 1, 0, 1);
    idle(0, 1);
    idle(0, 1);

    // x0 write is never reported as a GPR write.
    push(32'h8000_0004, 5'd0, 32'hdead_beef, 1, 0, 1);
    idle(0, 1);
    idle(0, 1);

    // Fill to DEPTH with the checker stalled, then one refused attempt.
    for (int unsigned i = 0; i < DEPTH + 1; i++)
      push(32'h8000_0100 + 32'(i * 4), 5'(i + 1), 32'(i), 1, 0, 0);
    repeat (DEPTH + 2) idle(1, 1);

    // Back-to-back push and pop across several pointer wraps.
    for (int unsigned i = 0; i < 11; i++)
      push(32'h8000_0200 + 32'(i * 4), 5'(i + 3), $urandom, 1, 0, 1);
    repeat (3) idle(0, 1);

    rnd(400, 0);
    repeat (DEPTH + 2) idle(1, 1);

    // Halt behind two queued commits.
    push(32'h8000_0008, 5'd1, 32'h11, 1, 0, 0);
    push(32'h8000_000c, 5'd2, 32'h22, 1, 0, 0);
    push(32'h8000_0010, 5'd0, 32'h0, 0, 1, 0);
    push(32'h8000_0014, 5'd3, 32'h33, 1, 0, 0);
    repeat (6) cyc(0, 0, 1'($urandom), $urandom, 0, 0, 1, 5'd7, $urandom, 1);

    // Reset in the middle of traffic flushes queued commits.
    cyc(1, 0, 0, '0, 0, 0, 0, '0, '0, 0);
    idle(1, 0);
    push(32'h9000_0000, 5'd4, 32'h44, 1, 0, 0);
    push(32'h9000_0004, 5'd5, 32'h55, 1, 0, 0);
    cyc(1, 0, 0, '0, 0, 0, 0, '0, '0, 0);
    repeat (2) idle(0, 1);

    // Long idle in RUN: watchdog fires after WDOG cycles only when enabled.
    idle(1, 0);
    repeat (WDOG + 4) idle(0, 1);
    cyc(1, 0, 0, '0, 0, 0, 0, '0, '0, 0);
    repeat (2) idle(0, 0);

    idle(1, 1);
    rnd(400, 1);
    repeat (DEPTH + 2) idle(0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
